display_multiplex: RTL

Parametrised multi-digit 7-segment display driver for the board's common-anode displays. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the digits onto one active-low segment bus with per-digit anode select. It is the next generation of the single-digit BCD-to-7-segment decoder and sits between counters/ALUs and the display pins.

---
 rtl/display_pkg.sv | 36 +++
 rtl/bcd_a_7seg.sv | 26 ++
 rtl/display_multiplex.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, converter state type and helpers for the multiplexed 7-segment driver.
package display_pkg;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0011000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // 32 bits holds 10^8, the largest limit needed
  localparam int unsigned POW10_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_e;

  function automatic logic [POW10_W-1:0] pow10(input int unsigned n);
    logic [POW10_W-1:0] r;
    r = POW10_W'(1);
    for (int unsigned i = 0; i < n; i++) begin
      r = r * POW10_W'(10);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_a_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_multiplex.sv
// Binary-to-BCD (double dabble) converter feeding a time-multiplexed common-anode display.
// Optional macro BLANK_LEADING_ZEROS_EN blanks leading zero digits above the units digit.
module display_multiplex
  import display_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  valor,
  input  logic              cargar,
  output logic              ocupado,
  output logic              listo,
  output logic              desborde,
  output logic [6:0]        segmentos,
  output logic [DIGITS-1:0] anodos
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [POW10_W-1:0] LIMIT = pow10(DIGITS);

  conv_state_e              state_q, state_d;
  logic [WIDTH-1:0]         bin_q, bin_d;
  logic [WIDTH-1:0]         cap_q, cap_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [BCD_W-1:0]         bcd_adj;
  logic [CNT_W-1:0]         iter_q, iter_d;
  logic [DIGITS-1:0][3:0]   disp_q, disp_d;
  logic                     desborde_q, desborde_d;
  logic                     listo_q, listo_d;
  logic                     ocupado_q, ocupado_d;

  logic [PRE_W-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [3:0]               nibble_c;
  logic [6:0]               dec_seg_c;
  logic                     blank_c;

  // Converter: capture, WIDTH add-3/shift steps, then publish to the display register
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    cap_d      = cap_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    disp_d     = disp_q;
    desborde_d = desborde_q;
    listo_d    = 1'b0;
    bcd_adj    = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cargar) begin
          bin_d   = valor;
          cap_d   = valor;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d  = (bcd_adj << 1) | BCD_W'(bin_q[WIDTH-1]);
        bin_d  = bin_q << 1;
        iter_d = iter_q + CNT_W'(1);
        if (iter_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        disp_d     = bcd_q;
        desborde_d = (POW10_W'(cap_q) >= LIMIT);
        listo_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ocupado_d = (state_d != ST_IDLE);
  end

  assign nibble_c = disp_q[idx_q];

  bcd_a_7seg u_dec (
    .bcd_i (nibble_c),
    .seg_o (dec_seg_c)
  );

`ifdef BLANK_LEADING_ZEROS_EN
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[i]: digits i..DIGITS-1 are all zero
  always_comb begin
    lead_zero = '0;
    lead_zero[DIGITS-1] = (disp_q[DIGITS-1] == 4'd0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (disp_q[i] == 4'd0);
    end
    blank_c = (idx_q != '0) && lead_zero[idx_q];
  end
`else
  assign blank_c = 1'b0;
`endif

  // Scan: prescaler, digit index and the registered segment/anode pair
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (desborde_q) begin
      seg_d = SEG_DASH;
    end else if (blank_c) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = dec_seg_c;
    end
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      cap_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      disp_q     <= '0;
      desborde_q <= 1'b0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_0;
      an_q       <= ~DIGITS'(1);
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      cap_q      <= cap_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      disp_q     <= disp_d;
      desborde_q <= desborde_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign desborde  = desborde_q;
  assign segmentos = seg_q;
  assign anodos    = an_q;

endmodule
